// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard unit and its multiply sequencer.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [3:0] PC_REG = 4'hF;

  localparam int unsigned MUL_CNT_W = 4;
  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  typedef enum logic {
    StIdle,
    StBusy
  } mulState_e;

  // Memory-stage result is younger than writeback, so it wins when both match.
  function automatic logic [1:0] fwdSel(
    input logic [3:0] src,
    input logic [3:0] wa3M,
    input logic       regWriteM,
    input logic [3:0] wa3W,
    input logic       regWriteW
  );
    if (src == PC_REG) begin
      return FWD_RF;
    end else if (regWriteM && (src == wa3M)) begin
      return FWD_M;
    end else if (regWriteW && (src == wa3W)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

  // Read-after-write hit against an in-flight producer, used when results cannot be bypassed.
  function automatic logic rawHit(
    input logic [3:0] src,
    input logic [3:0] wa3E,
    input logic       regWriteE,
    input logic [3:0] wa3M,
    input logic       regWriteM
  );
    return (src != PC_REG) &&
           ((regWriteE && (src == wa3E)) || (regWriteM && (src == wa3M)));
  endfunction

endpackage

// File: rtl/hazard_unit_mul_seq.sv
// Multi-cycle multiply sequencer: holds the pipeline busy for MUL_CYCLES-1 cycles after a start.
module mul_seq
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic MulStartE,
  input  logic PCSrcW,
  output logic MulBusy,
  output logic mulSquash
);

  mulState_e              state;
  logic [MUL_CNT_W-1:0]   cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= StIdle;
      cnt   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (MulStartE) begin
            state <= StBusy;
            cnt   <= MUL_CNT_W'(MUL_CYCLES - 2);
          end
        end
        StBusy: begin
          // A retiring PC write kills the multiply; new starts are ignored while busy.
          if (PCSrcW) begin
            state <= StIdle;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state <= StIdle;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= StIdle;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign MulBusy   = (state == StBusy);
  assign mulSquash = MulBusy & PCSrcW;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use/branch stalls and flushes, multiply stalls.
// Define HAZARD_FWD_EN to enable E-stage forwarding; otherwise RAW hazards stall in Decode.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  RA1D,
  input  logic [3:0]  RA2D,
  input  logic [3:0]  RA1E,
  input  logic [3:0]  RA2E,
  input  logic [3:0]  WA3E,
  input  logic [3:0]  WA3M,
  input  logic [3:0]  WA3W,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        PCSrcD,
  input  logic        PCSrcE,
  input  logic        PCSrcM,
  input  logic        PCSrcW,
  input  logic        BranchTakenE,
  input  logic        MulStartE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        MulBusy,
  output logic [15:0] StallCount
);

  logic ldStall;
  logic rawStall;
  logic dataStall;
  logic pcWrPending;
  logic mulSquash;

  mul_seq #(
    .MUL_CYCLES (MUL_CYCLES)
  ) uMulSeq (
    .clk       (clk),
    .reset     (reset),
    .MulStartE (MulStartE),
    .PCSrcW    (PCSrcW),
    .MulBusy   (MulBusy),
    .mulSquash (mulSquash)
  );

`ifndef HAZARD_FWD_EN
  logic unusedFwdInputs;
  assign unusedFwdInputs = ^{RA1E, RA2E, WA3W, RegWriteW};
`endif

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    rawStall  = 1'b0;
`ifdef HAZARD_FWD_EN
    ForwardAE = fwdSel(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
    ForwardBE = fwdSel(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);
`else
    rawStall  = rawHit(RA1D, WA3E, RegWriteE, WA3M, RegWriteM) |
                rawHit(RA2D, WA3E, RegWriteE, WA3M, RegWriteM);
`endif
  end

  always_comb begin
    ldStall     = ((RA1D == WA3E) || (RA2D == WA3E)) && MemtoRegE && RegWriteE;
    dataStall   = ldStall | rawStall;
    pcWrPending = PCSrcD | PCSrcE | PCSrcM;

    StallF = dataStall | pcWrPending | MulBusy;
    StallD = dataStall | MulBusy;
    StallE = MulBusy;
    FlushD = pcWrPending | PCSrcW | BranchTakenE;
    // E is frozen under a multiply, so the only flush allowed then is the squash.
    FlushE = MulBusy ? mulSquash : (dataStall | BranchTakenE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCount <= '0;
    end else if (StallF && (StallCount != STALL_CNT_MAX)) begin
      StallCount <= StallCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: driver pushes model predictions, negedge monitor checks.
module tb_hazard_unit;

  localparam int MC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, FlushD, FlushE, MulBusy;
  logic [15:0] StallCount;

  hazard_unit #(
    .MUL_CYCLES (MC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .RA1E         (RA1E),
    .RA2E         (RA2E),
    .WA3E         (WA3E),
    .WA3M         (WA3M),
    .WA3W         (WA3W),
    .RegWriteE    (RegWriteE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .MemtoRegE    (MemtoRegE),
    .PCSrcD       (PCSrcD),
    .PCSrcE       (PCSrcE),
    .PCSrcM       (PCSrcM),
    .PCSrcW       (PCSrcW),
    .BranchTakenE (BranchTakenE),
    .MulStartE    (MulStartE),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .MulBusy      (MulBusy),
    .StallCount   (StallCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic rwE, rwM, rwW, m2rE, pcD, pcE, pcM, pcW, brE, mulS;
  } vec_t;

  typedef struct packed {
    logic [1:0]  fa, fb;
    logic        sF, sD, sE, fD, fE, busy;
    logic [15:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: busy cycles still to come, and stalled cycles seen so far.
  int          remain = 0;
  int unsigned cntModel = 0;
  vec_t        prevV;
  exp_t        prevE;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [1:0] fwdRef(input logic [3:0] src, input vec_t v);
`ifdef HAZARD_FWD_EN
    if (src == 4'd15) return 2'b00;
    if (v.rwM && src == v.wa3m) return 2'b10;
    if (v.rwW && src == v.wa3w) return 2'b01;
    return 2'b00;
`else
    return 2'b00;
`endif
  endfunction

  function automatic bit rawRef(input logic [3:0] src, input vec_t v);
`ifdef HAZARD_FWD_EN
    return 1'b0;
`else
    if (src == 4'd15) return 1'b0;
    return (v.rwE && src == v.wa3e) || (v.rwM && src == v.wa3m);
`endif
  endfunction

  function automatic exp_t predict(input vec_t v, input int rem, input int unsigned cnt);
    exp_t e;
    bit busy, ld, data, pcPend;
    busy   = rem > 0;
    ld     = v.m2rE && v.rwE && (v.ra1d == v.wa3e || v.ra2d == v.wa3e);
    data   = ld || rawRef(v.ra1d, v) || rawRef(v.ra2d, v);
    pcPend = v.pcD || v.pcE || v.pcM;
    e.fa   = fwdRef(v.ra1e, v);
    e.fb   = fwdRef(v.ra2e, v);
    e.sF   = data || pcPend || busy;
    e.sD   = data || busy;
    e.sE   = busy;
    e.fD   = pcPend || v.pcW || v.brE;
    e.fE   = busy ? v.pcW : (data || v.brE);
    e.busy = busy;
    e.cnt  = 16'(cnt);
    return e;
  endfunction

  task automatic applyVec(input vec_t v);
    RA1D = v.ra1d; RA2D = v.ra2d; RA1E = v.ra1e; RA2E = v.ra2e;
    WA3E = v.wa3e; WA3M = v.wa3m; WA3W = v.wa3w;
    RegWriteE = v.rwE; RegWriteM = v.rwM; RegWriteW = v.rwW; MemtoRegE = v.m2rE;
    PCSrcD = v.pcD; PCSrcE = v.pcE; PCSrcM = v.pcM; PCSrcW = v.pcW;
    BranchTakenE = v.brE; MulStartE = v.mulS;
  endtask

  // rstMode: 0 reset low, 1 reset held this cycle, 2 reset pulsed between edges.
  task automatic step(input vec_t v, input int rstMode);
    exp_t e;
    @(posedge clk);
    if (!reset) begin
      if (prevE.sF && cntModel < 32'hFFFF) cntModel++;
      if (remain > 0) remain = prevV.pcW ? 0 : remain - 1;
      else if (prevV.mulS) remain = MC - 1;
    end
    #1;
    applyVec(v);
    reset = (rstMode == 1);
    if (rstMode == 1) begin
      remain = 0;
      cntModel = 0;
    end
    if (rstMode == 2) begin
      #2;
      reset = 1'b1;
      remain = 0;
      cntModel = 0;
      #1;
      chk("async_rst_MulBusy", 16'(MulBusy), 16'd0);
      chk("async_rst_StallCount", StallCount, 16'd0);
    end
    e = predict(v, remain, cntModel);
    sbq.push_back(e);
    prevV = v;
    prevE = e;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("ForwardAE", 16'(ForwardAE), 16'(e.fa));
      chk("ForwardBE", 16'(ForwardBE), 16'(e.fb));
      chk("StallF", 16'(StallF), 16'(e.sF));
      chk("StallD", 16'(StallD), 16'(e.sD));
      chk("StallE", 16'(StallE), 16'(e.sE));
      chk("FlushD", 16'(FlushD), 16'(e.fD));
      chk("FlushE", 16'(FlushE), 16'(e.fE));
      chk("MulBusy", 16'(MulBusy), 16'(e.busy));
      chk("StallCount", StallCount, e.cnt);
    end
  end

  function automatic logic [3:0] randReg();
    int p;
    p = $urandom_range(0, 4);
    return (p == 4) ? 4'd15 : 4'(p);
  endfunction

  function automatic vec_t randVec();
    vec_t v;
    v.ra1d = randReg(); v.ra2d = randReg(); v.ra1e = randReg(); v.ra2e = randReg();
    v.wa3e = randReg(); v.wa3m = randReg(); v.wa3w = randReg();
    v.rwE  = ($urandom_range(0, 1) == 0);
    v.rwM  = ($urandom_range(0, 1) == 0);
    v.rwW  = ($urandom_range(0, 1) == 0);
    v.m2rE = ($urandom_range(0, 3) == 0);
    v.pcD  = ($urandom_range(0, 9) == 0);
    v.pcE  = ($urandom_range(0, 9) == 0);
    v.pcM  = ($urandom_range(0, 9) == 0);
    v.pcW  = ($urandom_range(0, 7) == 0);
    v.brE  = ($urandom_range(0, 7) == 0);
    v.mulS = ($urandom_range(0, 5) == 0);
    return v;
  endfunction

  initial begin
    vec_t z, v;
    z = '0;
    prevV = '0;
    prevE = '0;
    applyVec(z);

    step(z, 1);
    step(z, 1);

    // Forwarding priority and PC exclusion.
    v = z; v.ra1e = 4'd3; v.wa3m = 4'd3; v.rwM = 1'b1; v.wa3w = 4'd3; v.rwW = 1'b1;
    step(v, 0);
    v.rwM = 1'b0;
    step(v, 0);
    v.ra1e = 4'd15;
    step(v, 0);

    // Load-use.
    v = z; v.m2rE = 1'b1; v.rwE = 1'b1; v.wa3e = 4'd5; v.ra2d = 4'd5; v.ra1d = 4'd1;
    step(v, 0);
    step(z, 0);

    // Multiply runs to completion.
    v = z; v.mulS = 1'b1;
    step(v, 0);
    for (int i = 0; i < 5; i++) step(z, 0);

    // Multiply squashed in its first busy cycle.
    step(v, 0);
    v = z; v.pcW = 1'b1;
    step(v, 0);
    for (int i = 0; i < 3; i++) step(z, 0);

    // Reset between edges while busy.
    v = z; v.mulS = 1'b1;
    step(v, 0);
    step(z, 0);
    step(z, 2);
    for (int i = 0; i < 3; i++) step(z, 0);

    // Memory-stage producer without bypass.
    v = z; v.ra1d = 4'd2; v.wa3m = 4'd2; v.rwM = 1'b1; v.wa3e = 4'd7;
    step(v, 0);

    for (int i = 0; i < 3000; i++) begin
      step(randVec(), ($urandom_range(0, 63) == 0) ? 2 : 0);
    end
    step(z, 0);

    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, giving the multiply latency in E-stage cycles; legal range 2..15.
REQ-002 SHALL have ports: clk in 1, clock; reset in 1, asynchronous active-high reset.
REQ-003 SHALL have inputs: RA1D, RA2D in 4, Decode source registers; RA1E, RA2E in 4, Execute source registers.
REQ-004 SHALL have inputs: WA3E, WA3M, WA3W in 4, destination registers in E, M and W.
REQ-005 SHALL have inputs: RegWriteE, RegWriteM, RegWriteW, MemtoRegE in 1, post-condition write controls.
REQ-006 SHALL have inputs: PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE in 1.
REQ-007 SHALL have outputs: ForwardAE, ForwardBE out 2, forward selects.
REQ-008 SHALL have outputs: StallF, StallD, StallE, FlushD, FlushE, MulBusy out 1.
REQ-009 SHALL have output StallCount out 16, count of stalled cycles.

Function
REQ-010 ForwardAE SHALL be 10 when RA1E==WA3M and RegWriteM; else 01 when RA1E==WA3W and RegWriteW; else 00. M beats W. ForwardBE uses RA2E the same way.
REQ-011 Forwarding SHALL be 00 whenever the source register is 4'hF (PC).
REQ-012 LdStall SHALL be (RA1D==WA3E or RA2D==WA3E) and MemtoRegE and RegWriteE.
REQ-013 LdStall SHALL assert StallF and StallD, and SHALL assert FlushE.
REQ-014 PCWrPending = PCSrcD|PCSrcE|PCSrcM SHALL assert StallF.
REQ-015 FlushD SHALL equal PCWrPending | PCSrcW | BranchTakenE.
REQ-016 FlushE SHALL also assert on BranchTakenE.
REQ-017 Multiply sequencer states: IDLE and BUSY.
- IDLE to BUSY: on MulStartE, loading a down-counter with MUL_CYCLES-2.
- BUSY: counter decrements each cycle; returns to IDLE the cycle after the counter reads 0.
- Net effect: StallF, StallD and StallE are high for exactly MUL_CYCLES-1 cycles after the start cycle.
REQ-018 MulBusy SHALL equal (state==BUSY).
REQ-019 While BUSY, StallF, StallD and StallE SHALL be 1, and FlushE SHALL be 0 unless REQ-020 applies.
REQ-020 PCSrcW while BUSY SHALL return the sequencer to IDLE on the next edge and SHALL assert FlushE that cycle, squashing the younger multiply.
REQ-021 MulStartE while BUSY SHALL be ignored.
REQ-022 StallCount SHALL increment on every cycle with StallF=1 and SHALL saturate at 16'hFFFF.
REQ-023 Outputs other than the sequencer state and StallCount SHALL be combinational, with zero latency.

Reset
REQ-024 reset SHALL asynchronously force state IDLE, counter 0, StallCount 0.
REQ-025 With reset high, all stall and flush outputs SHALL be 0, subject only to combinational inputs other than MUL state.
REQ-026 Reset asserted mid-multiply SHALL abandon the multiply with no further stall cycles.

Configuration
REQ-027 Macro HAZARD_FWD_EN defined: forwarding per REQ-010/011.
REQ-028 Macro HAZARD_FWD_EN undefined:
- ForwardAE and ForwardBE SHALL be tied to 00.
- StallF and StallD SHALL also assert and FlushE SHALL assert whenever RA1D or RA2D (not 4'hF) equals WA3E with RegWriteE, or equals WA3M with RegWriteM.

Structure
REQ-029 Package hazard_pkg SHALL hold:
- forward encodings FWD_RF=00, FWD_W=01, FWD_M=10;
- the sequencer state enum;
- the PC register constant 4'hF.
REQ-030 Sub-module mul_seq SHALL implement REQ-017..021 (state, counter, MulBusy); the rest SHALL stay in hazard_unit.

Verification
REQ-031 Forwarding: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10. Same with RegWriteM=0 -> 01. Same with RA1E=15 -> 00.
REQ-032 Load-use: MemtoRegE=1, RegWriteE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for one cycle, StallCount +1.
REQ-033 Multiply, MUL_CYCLES=4: MulStartE pulse -> MulBusy and StallE high for exactly 3 cycles, then IDLE.
REQ-034 Multiply squash: PCSrcW=1 in BUSY cycle 1 -> FlushE=1, IDLE next cycle, no further stalls.
REQ-035 Reset: async reset pulse during BUSY and between edges -> MulBusy=0 immediately, StallCount=0.
REQ-036 HAZARD_FWD_EN undefined: RA1D=2, WA3M=2, RegWriteM=1 -> StallD=1, FlushE=1, ForwardAE=00.
